// File: rtl/chess_pkg.sv
// Shared chess constants and types for the per-piece move rule blocks.
// Provides colour encodings, rank constants, allow-vector bit indices,
// the packed board-square type and a colour-relative rank helper.
package chess_pkg;

    localparam int unsigned RANK_W  = 3;
    localparam int unsigned FILE_W  = 3;
    localparam int unsigned SQ_W    = RANK_W + FILE_W;
    localparam int unsigned ALLOW_W = 3;

    // Pawn colour encodings
    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // Ranks as seen from white: RANK_1 is white's back rank
    localparam logic [RANK_W-1:0] RANK_1 = 3'd0;
    localparam logic [RANK_W-1:0] RANK_2 = 3'd1;
    localparam logic [RANK_W-1:0] RANK_3 = 3'd2;
    localparam logic [RANK_W-1:0] RANK_4 = 3'd3;
    localparam logic [RANK_W-1:0] RANK_5 = 3'd4;
    localparam logic [RANK_W-1:0] RANK_6 = 3'd5;
    localparam logic [RANK_W-1:0] RANK_7 = 3'd6;
    localparam logic [RANK_W-1:0] RANK_8 = 3'd7;

    // Bit positions inside the allow vector
    localparam int unsigned ALLOW_SINGLE = 0;
    localparam int unsigned ALLOW_DOUBLE = 1;
    localparam int unsigned ALLOW_PROMO  = 2;

    typedef logic [RANK_W-1:0]  rank_t;
    typedef logic [FILE_W-1:0]  file_t;
    typedef logic [ALLOW_W-1:0] allow_t;

    // Board square, index = rank*8 + file
    typedef struct packed {
        rank_t rank;
        file_t file;
    } square_t;

    // Rank as seen from the pawn's own side: black ranks are mirrored so
    // that both colours advance from RANK_2 towards RANK_8.
    function automatic rank_t rel_rank(input rank_t rank, input logic color);
        rel_rank = (color == BLACK) ? rank_t'(RANK_8 - rank) : rank;
    endfunction

endpackage : chess_pkg

// File: rtl/pawn_rules_comb.sv
// Combinational pawn forward-move rule function.
// Ports:
//   pos_i    : pawn square {rank, file}
//   color_i  : pawn colour (WHITE/BLACK)
//   allow_c  : unregistered permission flags {promo, double, single}
module pawn_rules_comb
    import chess_pkg::*;
(
    input  logic [5:0] pos_i,
    input  logic       color_i,
    output logic [2:0] allow_c
);

    square_t sq;
    rank_t   rrank;
    file_t   unused_file;

    assign sq          = square_t'(pos_i);
    assign rrank       = rel_rank(sq.rank, color_i);
    // Pawn pushes are file-independent
    assign unused_file = sq.file;

    // Rule table over the colour-relative rank
    always_comb begin
        allow_c = '0;
        unique case (rrank)
            // Own back rank is not a legal pawn square; last rank has no forward square
            RANK_1, RANK_8: allow_c = '0;
            RANK_2: begin
                allow_c[ALLOW_SINGLE] = 1'b1;
                allow_c[ALLOW_DOUBLE] = 1'b1;
            end
            RANK_3, RANK_4, RANK_5, RANK_6: begin
                allow_c[ALLOW_SINGLE] = 1'b1;
            end
            RANK_7: begin
                allow_c[ALLOW_SINGLE] = 1'b1;
                allow_c[ALLOW_PROMO]  = 1'b1;
            end
            default: allow_c = '0;
        endcase
    end

endmodule : pawn_rules_comb

// File: rtl/pawn_move_allow.sv
// Registered pawn move-permission generator.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   pos       : pawn square {rank[2:0], file[2:0]}
//   colorPawn : 0 = white, 1 = black
//   allow     : registered flags [0] single, [1] double, [2] promotion
module pawn_move_allow
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pos,
    input  logic       colorPawn,
    output logic [2:0] allow
);

    allow_t allow_d;
    allow_t allow_q;

    pawn_rules_comb u_rules (
        .pos_i   (pos),
        .color_i (colorPawn),
        .allow_c (allow_d)
    );

    // Output register; reset wins over any evaluation
    always_ff @(posedge clk) begin
        if (!reset) begin
            allow_q <= '0;
        end else begin
            allow_q <= allow_d;
        end
    end

    assign allow = allow_q;

endmodule : pawn_move_allow

// File: tb/tb_pawn_move_allow.sv
// Scoreboard bench for pawn_move_allow: expected values from a rank-arithmetic model.
module tb_pawn_move_allow;

    logic       clk;
    logic       reset;
    logic [5:0] pos;
    logic       colorPawn;
    logic [2:0] allow;

    pawn_move_allow dut (
        .clk       (clk),
        .reset     (reset),
        .pos       (pos),
        .colorPawn (colorPawn),
        .allow     (allow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] exp;
        string      name;
    } exp_t;

    exp_t  sb_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    tracking = 1'b0;
    string cur_name = "idle";

    // Reference: forward motion as signed rank arithmetic
    function automatic logic [2:0] model(input int p, input int c);
        int r, dir, fwd, start_r, back_r;
        logic [2:0] res;
        r       = p / 8;
        dir     = (c != 0) ? -1 : 1;
        start_r = (c != 0) ? 6 : 1;
        back_r  = (c != 0) ? 7 : 0;
        fwd     = r + dir;
        res     = 3'b000;
        if (r != back_r && fwd >= 0 && fwd <= 7) begin
            res[0] = 1'b1;
            res[1] = (r == start_r);
            res[2] = (fwd == 0 || fwd == 7);
        end
        return res;
    endfunction

    // Expected result for the inputs captured at this edge
    always @(posedge clk) begin
        if (tracking) begin
            exp_t e;
            e.exp  = (reset == 1'b0) ? 3'b000 : model(int'(pos), int'(colorPawn));
            e.name = cur_name;
            sb_q.push_back(e);
        end
    end

    // Monitor: one registered result is due after every tracked edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (allow !== e.exp) begin
                errors++;
                $display("FAIL %s: allow=%b expected=%b", e.name, allow, e.exp);
            end
        end
    end

    task automatic drive(input logic [5:0] p, input logic c, input logic rst, input string nm);
        @(negedge clk);
        pos       = p;
        colorPawn = c;
        reset     = rst;
        cur_name  = nm;
    endtask

    // Directed vectors with hand-derived expectations checked independently of model()
    task automatic directed(input logic [5:0] p, input logic c, input logic [2:0] want, input string nm);
        drive(p, c, 1'b1, nm);
        checks++;
        if (model(int'(p), int'(c)) !== want) begin
            errors++;
            $display("FAIL model_%s: model=%b expected=%b", nm, model(int'(p), int'(c)), want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, pending=%0d", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int order[128];
        int reset_at;

        pos       = 6'd12;
        colorPawn = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        tracking = 1'b1;

        // Reset held for three edges, then released
        cur_name = "reset_hold";
        repeat (3) @(negedge clk);
        drive(6'd12, 1'b0, 1'b1, "reset_release_e2");

        directed(6'd12, 1'b0, 3'b011, "white_start_e2");
        directed(6'd28, 1'b0, 3'b001, "white_mid_e4");
        directed(6'd52, 1'b1, 3'b011, "black_start_e7");
        directed(6'd36, 1'b1, 3'b001, "black_mid_e5");
        directed(6'd48, 1'b0, 3'b101, "white_promo_a7");
        directed(6'd15, 1'b1, 3'b101, "black_promo_h2");
        directed(6'd63, 1'b0, 3'b000, "white_rank8");
        directed(6'd0,  1'b0, 3'b000, "white_rank1");
        directed(6'd7,  1'b1, 3'b000, "black_rank1");
        directed(6'd56, 1'b1, 3'b000, "black_rank8");

        // Exhaustive sweep in shuffled order with one reset pulse mid-way
        for (int i = 0; i < 128; i++) order[i] = i;
        for (int i = 127; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        reset_at = int'($urandom_range(100, 20));
        for (int i = 0; i < 128; i++) begin
            if (i == reset_at)
                drive(6'(order[i] >> 1), order[i][0], 1'b0, "sweep_reset");
            drive(6'(order[i] >> 1), order[i][0], 1'b1, "sweep");
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 150; i++) begin
            drive(6'($urandom), 1'($urandom), ($urandom_range(15, 0) != 0), "random");
        end

        @(negedge clk);
        tracking = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pawn_move_allow
